// File: rtl/modn_updown_counter.sv
// +----------------------------------------------------------------------------+
// | modn_updown_counter: modulo-N up/down counter, wrap or saturate mode.      |
// | Optional parallel load under MODN_LOAD_EN.  Rev 1.0                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module modn_updown_counter #(
  parameter int MODULUS = 5,
  parameter int WIDTH   = 3
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             En,
  input  logic             Dir,
  input  logic             Sat,
`ifdef MODN_LOAD_EN
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  output logic             LoadErr,
`endif
  output logic [WIDTH-1:0] Count,
  output logic             Wrap,
  output logic             AtMax,
  output logic             AtZero
);

  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;

  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
`ifdef MODN_LOAD_EN
    if (Load) begin
      if ({1'b0, LoadVal} < (WIDTH + 1)'(MODULUS)) begin
        count_d = LoadVal;
      end else begin
        count_d    = C_MAX;
        load_err_d = 1'b1;
      end
    end else
`endif
    // Encodings above MODULUS-1 are recovered to 0 regardless of En.
    if (count_q > C_MAX) begin
      count_d = '0;
    end else if (En) begin
      if (!Dir) begin
        if (count_q == C_MAX) begin
          if (!Sat) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          if (!Sat) begin
            count_d = C_MAX;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign Count  = count_q;
  assign Wrap   = wrap_q;
  assign AtMax  = (count_q == C_MAX);
  assign AtZero = (count_q == '0);
`ifdef MODN_LOAD_EN
  assign LoadErr = load_err_q;
`else
  logic unused_load_err;
  assign unused_load_err = load_err_q;
`endif

endmodule

`default_nettype wire

// File: doc/modn_updown_counter.md
# modn_updown_counter

Parametrised modulo-N up/down counter: the next generation of the team's mod-5 up/down state machine. Adds configurable modulus and width, a count enable, a wrap-or-saturate mode, terminal-count flags and an optional parallel load. It serves as a reusable sequencing and count element in lab datapaths. Typical hookups are a debounced key or a clock-divider tick into `En`, and a switch into `Dir`.

## Interface
Parameters:
- `MODULUS`, default 5: number of states. Count range is 0..MODULUS-1. Legal range is 2..2^WIDTH.
- `WIDTH`, default 3: counter width in bits.

Ports:
- `Clock` in 1: system clock. The block uses a single clock with one clock domain.
- `Reset` in 1: reset. It is synchronous and active-low.
- `En` in 1: count enable. While `En`=0, the count holds.
- `Dir` in 1: direction. 0 counts up; 1 counts down.
- `Sat` in 1: mode select. 0 selects wrap (modulo); 1 selects saturate at the range ends.
- `Load` in 1: parallel load strobe. This port exists only with `MODN_LOAD_EN`.
- `LoadVal` in WIDTH: value to load. This port exists only with `MODN_LOAD_EN`.
- `Count` out WIDTH: current state.
- `Wrap` out 1: one-cycle pulse marking a modulo wrap.
- `AtMax` out 1: high when `Count` equals MODULUS-1.
- `AtZero` out 1: high when `Count` equals 0.
- `LoadErr` out 1: one-cycle pulse for an out-of-range load. This port exists only with `MODN_LOAD_EN`.

## Operation
- The counter is a state machine. Its state register is `Count`, holding states 0..MODULUS-1, and each clock edge selects the next state.
- Reset values: `Count`=0, `Wrap`=0, `LoadErr`=0. Outputs therefore read `AtZero`=1 and `AtMax`=0.
- Priority per edge, highest first: `Reset` low, then `Load`, then `En`, then hold.
- Up step (`Dir`=0):
  - Below MODULUS-1, the count increments.
  - At MODULUS-1 with `Sat`=0, the count goes to 0 and `Wrap` pulses.
  - At MODULUS-1 with `Sat`=1, the count stays at MODULUS-1 and `Wrap` stays 0.
- Down step (`Dir`=1):
  - Above 0, the count decrements.
  - At 0 with `Sat`=0, the count goes to MODULUS-1 and `Wrap` pulses.
  - At 0 with `Sat`=1, the count stays at 0 and `Wrap` stays 0.
- Hold (`En`=0): the count is unchanged. `Wrap` and `LoadErr` are 0.
- Load:
  - If `LoadVal` < MODULUS, the count takes `LoadVal`.
  - Otherwise, the count takes MODULUS-1 and `LoadErr` pulses.
  - A load never asserts `Wrap`, and it overrides `En`, `Dir` and `Sat` in the same cycle.
- Arithmetic: next-state logic compares against MODULUS-1 explicitly, so behaviour is correct for non-power-of-2 moduli. When MODULUS = 2^WIDTH, the natural binary rollover must match the explicit wrap rule.
- Unreachable encodings (MODULUS..2^WIDTH-1) are forced to 0 on the next edge, whatever the inputs, except `Reset` or `Load`. `Wrap` is not asserted in this case.
- `Dir` and `Sat` may change on any cycle. Each takes effect on the edge at which it is sampled.

## Timing
- All state updates happen on the rising edge of `Clock`.
- Latency:
  - The input-to-`Count` change takes one cycle.
  - `Wrap` and `LoadErr` are registered. They are high for exactly the one cycle in which `Count` shows the post-wrap or post-load value.
- `AtMax` and `AtZero` are decoded combinationally from the `Count` register and add no extra latency.
- Reset:
  - Reset in mid-count returns the counter to 0 on the sampling edge.
  - `Wrap` and `LoadErr` are cleared in the same edge, even if a wrap or load was due.
- Back-to-back wraps are legal, e.g. MODULUS=2 counting continuously. In that case `Wrap` pulses on every other cycle.
- Simultaneous `Load` and wrap condition: the load wins and `Wrap`=0.

## Configuration
- `MODN_LOAD_EN` defined: the `Load`, `LoadVal` and `LoadErr` ports and the load behaviour exist.
- `MODN_LOAD_EN` undefined:
  - Those three ports are absent and there is no load path.
  - Priority reduces to `Reset` > `En` > hold.
  - All other behaviour is identical.

## Test plan
- Default parameters, wrap mode (MODULUS=5, `Sat`=0), `En`=1:
  - Up for 6 cycles from reset: `Count` goes 1,2,3,4,0,1. `Wrap` is high only on the cycle where `Count`=0.
  - Down for 2 cycles from reset: `Count` goes 4,3. `Wrap` is high on the cycle where `Count`=4.
- Default parameters, `Sat`=1: up for 7 cycles holds at 4 with `AtMax`=1 and `Wrap` never asserted. Then down for 6 cycles holds at 0 with `AtZero`=1.
- `En` toggling 1,0,0,1 while counting up from 2: `Count` reads 3,3,3,4.
- With `MODN_LOAD_EN`:
  - Load 3: `Count`=3 next cycle.
  - Load 6 with MODULUS=5: `Count`=4 and `LoadErr` pulses for one cycle.
  - `Load`=1 and `En`=1 at `Count`=4 going up: the load wins and `Wrap`=0.
- `Reset` low for one cycle while `Count`=4 and a wrap is due: next `Count`=0 with `Wrap`=0. Also run a sweep with MODULUS=8, WIDTH=3: the counter wraps 7→0 with `Wrap` high.
